// File: rtl/benchmark_frame_driver.sv
// Replays preloaded input frames into the jet-tagging core and collects each
// result frame together with its issue-to-response latency.
module benchmark_frame_driver #(
  parameter int unsigned WIDTH       = 37,
  parameter int unsigned INPUT_SIZE  = 16,
  parameter int unsigned OUTPUT_SIZE = 5,
  parameter int unsigned NUM_VECTORS = 8,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned LAT_W       = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_VECTORS)
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      start,
  input  logic                                      vec_wr_en,
  input  logic [IDX_W-1:0]                          vec_wr_addr,
  input  logic signed [INPUT_SIZE-1:0][WIDTH-1:0]   vec_wr_data,
  output logic                                      input_ready,
  output logic signed [INPUT_SIZE-1:0][WIDTH-1:0]   input_data,
  input  logic                                      output_ready,
  input  logic signed [OUTPUT_SIZE-1:0][WIDTH-1:0]  output_data,
  input  logic [IDX_W-1:0]                          res_rd_addr,
  output logic signed [OUTPUT_SIZE-1:0][WIDTH-1:0]  res_rd_data,
  output logic [LAT_W-1:0]                          res_rd_lat,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      timeout_err,
  output logic [7:0]                                stray_cnt
);

  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                                   state_q, state_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic [LAT_W-1:0]                         lat_cnt;
  logic [LAT_W-1:0]                         lat_q;
  logic signed [OUTPUT_SIZE-1:0][WIDTH-1:0] out_q;
  logic                                     timeout_hit;

  logic signed [INPUT_SIZE-1:0][WIDTH-1:0]  vec_mem [NUM_VECTORS];
  logic signed [OUTPUT_SIZE-1:0][WIDTH-1:0] res_mem [NUM_VECTORS];
  logic [LAT_W-1:0]                         lat_mem [NUM_VECTORS];

  // A response arriving on the last allowed WAIT cycle still wins over the timeout.
  assign timeout_hit = (state_q == S_WAIT) && !output_ready && (lat_cnt == LAT_LIMIT);

  // Next-state and frame index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (output_ready)             state_d = S_CAPTURE;
        else if (lat_cnt == LAT_LIMIT) state_d = S_DONE;
      end
      S_CAPTURE: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, registered outputs, latency counter and response holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      lat_cnt     <= '0;
      lat_q       <= '0;
      out_q       <= '0;
      input_ready <= 1'b0;
      input_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      stray_cnt   <= '0;
      res_rd_data <= '0;
      res_rd_lat  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      input_ready <= (state_d == S_ISSUE);
      busy        <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CAPTURE);

      if (state_d == S_ISSUE) input_data <= vec_mem[idx_d];

      if (state_q == S_ISSUE)     lat_cnt <= '0;
      else if (state_q == S_WAIT) lat_cnt <= lat_cnt + LAT_W'(1);

      if ((state_q == S_WAIT) && output_ready) begin
        out_q <= output_data;
        lat_q <= lat_cnt + LAT_W'(1);
      end

      if ((state_q == S_IDLE) && start) begin
        done        <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state_d == S_DONE) done        <= 1'b1;
      if (timeout_hit)       timeout_err <= 1'b1;

      if (output_ready && (state_q != S_WAIT) && (stray_cnt != 8'hFF))
        stray_cnt <= stray_cnt + 8'd1;

      res_rd_data <= res_mem[res_rd_addr];
      res_rd_lat  <= lat_mem[res_rd_addr];
    end
  end

  // Storage arrays are deliberately left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (vec_wr_en && !busy) vec_mem[vec_wr_addr] <= vec_wr_data;
    if (state_q == S_CAPTURE) begin
      res_mem[idx_q] <= out_q;
      lat_mem[idx_q] <= lat_q;
    end else if (timeout_hit) begin
      lat_mem[idx_q] <= '1;
    end
  end

endmodule
